// File: rtl/lamp_fpu_round_pack.sv
// -----------------------------------------------------------------------------
// lamp_fpu_round_pack
//
// Rounding and packing stage of the bfloat16 LAMP FPU, directly downstream of
// the multiplier. It takes the registered sign, exponent and extended fraction
// (hidden, fraction, guard, round, sticky) plus the overflow, underflow and
// to-round flags, and applies one of four IEEE-754 rounding modes. It then
// packs a {sign, exponent, fraction} result and accumulates sticky exception
// flags.
//
// The stage is a two-deep valid/ready pipeline. Stage A registers the rounded
// result. Stage B is the output register. When the consumer stalls, up to two
// results are buffered and nothing is lost.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   valid_i        input operation valid
//   ready_o        stage can accept an input this cycle (combinational)
//   s_i            result sign
//   e_i            biased exponent after post-normalization
//   f_i            {ovf(ignored), hidden, fraction[F_DW-1:0], G, R, S}
//   isOverflow_i   upstream exponent overflow
//   isUnderflow_i  upstream result is tiny
//   isToRound_i    0 = special value, passed through untouched
//   rndMode_i      00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   valid_o        result valid
//   ready_i        downstream accepts result
//   res_o          packed {s, e, f}
//   isInexact_o    per-result inexact flag, qualified by valid_o
//   isOverflow_o   per-result overflow flag, qualified by valid_o
//   isUnderflow_o  per-result underflow flag, qualified by valid_o
//   flags_o        sticky {overflow, underflow, inexact}
//   flagsClr_i     clear sticky flags
// -----------------------------------------------------------------------------
module lamp_fpu_round_pack #(
  parameter int E_DW = 8,
  parameter int F_DW = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     s_i,
  input  logic [E_DW-1:0]          e_i,
  input  logic [F_DW+4:0]          f_i,
  input  logic                     isOverflow_i,
  input  logic                     isUnderflow_i,
  input  logic                     isToRound_i,
  input  logic [1:0]               rndMode_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [E_DW+F_DW:0]       res_o,
  output logic                     isInexact_o,
  output logic                     isOverflow_o,
  output logic                     isUnderflow_o,
  output logic [2:0]               flags_o,
  input  logic                     flagsClr_i
);

  localparam int RES_W = 1 + E_DW + F_DW;
  localparam int SUM_W = E_DW + F_DW;

  localparam logic [1:0] RND_RNE = 2'b00;
  localparam logic [1:0] RND_RTZ = 2'b01;
  localparam logic [1:0] RND_RDN = 2'b10;
  localparam logic [1:0] RND_RUP = 2'b11;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // One-ulp round increment for the selected mode.
  function automatic logic roundInc(
    input logic [1:0] mode,
    input logic       sign,
    input logic       lsb,
    input logic       g,
    input logic       r,
    input logic       s
  );
    logic inexact;
    inexact = g | r | s;
    case (mode)
      RND_RNE: roundInc = g & (r | s | lsb);
      RND_RTZ: roundInc = 1'b0;
      RND_RDN: roundInc = sign & inexact;
      RND_RUP: roundInc = ~sign & inexact;
      default: roundInc = 1'b0;
    endcase
  endfunction

  // Saturated result on overflow: infinity when the mode rounds away from
  // zero for this sign, otherwise the largest finite magnitude.
  function automatic logic [RES_W-1:0] overflowRes(
    input logic [1:0] mode,
    input logic       sign
  );
    logic [RES_W-1:0] infRes;
    logic [RES_W-1:0] maxRes;
    infRes = {sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
    maxRes = {sign, {(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};
    case (mode)
      RND_RNE: overflowRes = infRes;
      RND_RTZ: overflowRes = maxRes;
      RND_RDN: overflowRes = sign ? infRes : maxRes;
      RND_RUP: overflowRes = sign ? maxRes : infRes;
      default: overflowRes = infRes;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Rounding datapath (feeds stage A)
  // ---------------------------------------------------------------------------
  logic             lsb_s;
  logic             guard_s;
  logic             round_s;
  logic             sticky_s;
  logic             inexact_s;
  logic             inc_s;
  logic [SUM_W-1:0] sum_s;
  logic             sumOvf_s;
  logic [RES_W-1:0] rndRes_s;
  logic             rndInexact_s;
  logic             rndOverflow_s;
  logic             rndUnderflow_s;

  // The overflow bit and the hidden bit never affect the packed result: the
  // hidden bit is implicit in the exponent, and a subnormal that rounds up
  // into it carries into the exponent field by itself. They are gathered here
  // only so that every input bit is read.
  logic unusedTopBits_s;
  assign unusedTopBits_s = ^f_i[F_DW+4:F_DW+3];

  // Round increment, packed sum and per-result flags for the incoming operation.
  always_comb begin
    lsb_s     = f_i[3];
    guard_s   = f_i[2];
    round_s   = f_i[1];
    sticky_s  = f_i[0];
    inexact_s = guard_s | round_s | sticky_s;
    inc_s     = roundInc(rndMode_i, s_i, lsb_s, guard_s, round_s, sticky_s);

    // A fraction carry ripples into the exponent field through the adder.
    sum_s    = {e_i, f_i[F_DW+2:3]} + {{(SUM_W-1){1'b0}}, inc_s};
    sumOvf_s = &sum_s[SUM_W-1:F_DW];

    rndRes_s       = {s_i, e_i, f_i[F_DW+2:3]};
    rndInexact_s   = 1'b0;
    rndOverflow_s  = 1'b0;
    rndUnderflow_s = 1'b0;

    if (!isToRound_i) begin
      // Zero, infinity and NaN pass through with no exceptions.
      rndRes_s       = {s_i, e_i, f_i[F_DW+2:3]};
      rndInexact_s   = 1'b0;
      rndOverflow_s  = 1'b0;
      rndUnderflow_s = 1'b0;
    end else if (isOverflow_i || sumOvf_s) begin
      rndRes_s       = overflowRes(rndMode_i, s_i);
      rndInexact_s   = 1'b1;
      rndOverflow_s  = 1'b1;
      rndUnderflow_s = isUnderflow_i & inexact_s;
    end else begin
      rndRes_s       = {s_i, sum_s};
      rndInexact_s   = inexact_s;
      rndOverflow_s  = 1'b0;
      rndUnderflow_s = isUnderflow_i & inexact_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic             validA_r;
  logic [RES_W-1:0] resA_r;
  logic             inexactA_r;
  logic             overflowA_r;
  logic             underflowA_r;
  logic             loadB_s;
  logic             loadA_s;
  logic             outHs_s;
  logic [2:0]       newFlags_s;

  // Handshake terms: B can take a new entry whenever it is empty or draining;
  // A can take a new entry whenever it is empty or moving into B.
  always_comb begin
    loadB_s = ~valid_o | ready_i;
    ready_o = ~validA_r | loadB_s;
    loadA_s = valid_i & ready_o;
    outHs_s = valid_o & ready_i;
    if (outHs_s) begin
      newFlags_s = {isOverflow_o, isUnderflow_o, isInexact_o};
    end else begin
      newFlags_s = 3'b000;
    end
  end

  // Stage A: captures the rounded result of an accepted operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validA_r     <= 1'b0;
      resA_r       <= {RES_W{1'b0}};
      inexactA_r   <= 1'b0;
      overflowA_r  <= 1'b0;
      underflowA_r <= 1'b0;
    end else if (ready_o) begin
      // ready_o with A full implies A is moving into B this edge.
      validA_r <= valid_i;
      if (loadA_s) begin
        resA_r       <= rndRes_s;
        inexactA_r   <= rndInexact_s;
        overflowA_r  <= rndOverflow_s;
        underflowA_r <= rndUnderflow_s;
      end
    end
  end

  // Stage B: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o       <= 1'b0;
      res_o         <= {RES_W{1'b0}};
      isInexact_o   <= 1'b0;
      isOverflow_o  <= 1'b0;
      isUnderflow_o <= 1'b0;
    end else if (loadB_s) begin
      valid_o <= validA_r;
      if (validA_r) begin
        res_o         <= resA_r;
        isInexact_o   <= inexactA_r;
        isOverflow_o  <= overflowA_r;
        isUnderflow_o <= underflowA_r;
      end
    end
  end

  // Sticky exception flags: a clear and a coinciding new flag leave the new flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_o <= 3'b000;
    end else begin
      flags_o <= (flagsClr_i ? 3'b000 : flags_o) | newFlags_s;
    end
  end

endmodule

// File: tb/tb_lamp_fpu_round_pack.sv
// -----------------------------------------------------------------------------
// tb_lamp_fpu_round_pack
//
// Directed bench for the bfloat16 round/pack stage. Expected results are
// hand-computed bf16 encodings.
// -----------------------------------------------------------------------------
module tb_lamp_fpu_round_pack;

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RDN = 2'b10;
  localparam logic [1:0] RUP = 2'b11;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isOverflow_i;
  logic        isUnderflow_i;
  logic        isToRound_i;
  logic [1:0]  rndMode_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;
  logic        isInexact_o;
  logic        isOverflow_o;
  logic        isUnderflow_o;
  logic [2:0]  flags_o;
  logic        flagsClr_i;

  int checks;
  int failures;

  lamp_fpu_round_pack #(.E_DW(8), .F_DW(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .isToRound_i   (isToRound_i),
    .rndMode_i     (rndMode_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .res_o         (res_o),
    .isInexact_o   (isInexact_o),
    .isOverflow_o  (isOverflow_o),
    .isUnderflow_o (isUnderflow_o),
    .flags_o       (flags_o),
    .flagsClr_i    (flagsClr_i)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation with ready_i=1, wait for its result and check it.
  // The result handshake edge is consumed here, with flagsClr_i = clr on it.
  task automatic runOp(input string tag, input logic s, input logic [7:0] e,
                       input logic [11:0] f, input logic ovf, input logic unf,
                       input logic toRound, input logic [1:0] mode, input logic clr,
                       input logic [15:0] expRes, input logic expInx,
                       input logic expOvf, input logic expUnf);
    logic seen;
    @(negedge clk);
    s_i = s; e_i = e; f_i = f;
    isOverflow_i = ovf; isUnderflow_i = unf; isToRound_i = toRound;
    rndMode_i = mode; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    checkEq({tag, "_valid"}, {31'd0, seen}, 32'd1);
    checkEq({tag, "_res"}, {16'd0, res_o}, {16'd0, expRes});
    checkEq({tag, "_inexact"}, {31'd0, isInexact_o}, {31'd0, expInx});
    checkEq({tag, "_overflow"}, {31'd0, isOverflow_o}, {31'd0, expOvf});
    checkEq({tag, "_underflow"}, {31'd0, isUnderflow_o}, {31'd0, expUnf});
    flagsClr_i = clr;
    @(posedge clk);
    #1 flagsClr_i = 1'b0;
  endtask

  task automatic clearFlags();
    @(negedge clk);
    flagsClr_i = 1'b1;
    @(posedge clk);
    #1 flagsClr_i = 1'b0;
  endtask

  logic [11:0] bpF   [3];
  logic [15:0] bpExp [3];
  logic [15:0] got   [3];
  logic        rdyAt [6];
  int          accepted;
  int          n;
  logic        hs;

  initial begin
    checks = 0; failures = 0;
    bpF[0] = 12'h404; bpF[1] = 12'h40C; bpF[2] = 12'h7FE;
    bpExp[0] = 16'h3F80; bpExp[1] = 16'h3F82; bpExp[2] = 16'h4000;
    for (int i = 0; i < 3; i++) got[i] = 16'h0000;
    rst = 1'b1; valid_i = 1'b0; s_i = 1'b0; e_i = 8'h00; f_i = 12'h000;
    isOverflow_i = 1'b0; isUnderflow_i = 1'b0; isToRound_i = 1'b1;
    rndMode_i = RNE; ready_i = 1'b1; flagsClr_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_valid", {31'd0, valid_o}, 32'd0);
    checkEq("rst_res", {16'd0, res_o}, 32'd0);
    checkEq("rst_flags", {29'd0, flags_o}, 32'd0);
    checkEq("rst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk) rst = 1'b0;

    // Rounding and sticky flag behaviour.
    runOp("rne_tie_even", 1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1, RNE, 1'b0, 16'h3F80, 1'b1, 1'b0, 1'b0);
    checkEq("sticky_inexact", {29'd0, flags_o}, 32'h1);
    clearFlags();
    checkEq("sticky_clear", {29'd0, flags_o}, 32'h0);
    runOp("rne_tie_odd", 1'b0, 8'h7F, 12'h40C, 1'b0, 1'b0, 1'b1, RNE, 1'b1, 16'h3F82, 1'b1, 1'b0, 1'b0);
    checkEq("sticky_clear_with_hs", {29'd0, flags_o}, 32'h1);
    runOp("carry_exp", 1'b0, 8'h7F, 12'h7FE, 1'b0, 1'b0, 1'b1, RNE, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b0);
    runOp("rup_pos", 1'b0, 8'h7F, 12'h401, 1'b0, 1'b0, 1'b1, RUP, 1'b0, 16'h3F81, 1'b1, 1'b0, 1'b0);
    runOp("rdn_pos", 1'b0, 8'h7F, 12'h401, 1'b0, 1'b0, 1'b1, RDN, 1'b0, 16'h3F80, 1'b1, 1'b0, 1'b0);
    runOp("ovf_rne", 1'b0, 8'hFE, 12'h7FC, 1'b0, 1'b0, 1'b1, RNE, 1'b0, 16'h7F80, 1'b1, 1'b1, 1'b0);
    checkEq("sticky_ovf", {29'd0, flags_o}, 32'h5);
    runOp("ovf_rtz", 1'b0, 8'hFE, 12'h7FC, 1'b0, 1'b0, 1'b1, RTZ, 1'b0, 16'h7F7F, 1'b1, 1'b0, 1'b0);
    runOp("ovf_rup_neg", 1'b1, 8'hFE, 12'h7FC, 1'b0, 1'b0, 1'b1, RUP, 1'b0, 16'hFF7F, 1'b1, 1'b0, 1'b0);
    runOp("bypass_nan", 1'b0, 8'hFF, 12'h600, 1'b0, 1'b0, 1'b0, RNE, 1'b0, 16'h7FC0, 1'b0, 1'b0, 1'b0);
    checkEq("bypass_sticky", {29'd0, flags_o}, 32'h5);
    runOp("force_ovf_rdn_pos", 1'b0, 8'hFE, 12'h400, 1'b1, 1'b0, 1'b1, RDN, 1'b0, 16'h7F7F, 1'b1, 1'b1, 1'b0);
    runOp("force_ovf_rdn_neg", 1'b1, 8'hFE, 12'h400, 1'b1, 1'b0, 1'b1, RDN, 1'b0, 16'hFF80, 1'b1, 1'b1, 1'b0);
    runOp("subnorm_to_normal", 1'b0, 8'h00, 12'h3FF, 1'b0, 1'b1, 1'b1, RNE, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b1);
    checkEq("sticky_all", {29'd0, flags_o}, 32'h7);

    // Backpressure: three offers against a stalled consumer.
    clearFlags();
    checkEq("bp_flags_cleared", {29'd0, flags_o}, 32'h0);
    @(negedge clk) ready_i = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (accepted < 3) begin
        s_i = 1'b0; e_i = 8'h7F; f_i = bpF[accepted];
        isOverflow_i = 1'b0; isUnderflow_i = 1'b0; isToRound_i = 1'b1;
        rndMode_i = RNE; valid_i = 1'b1;
      end
      rdyAt[c] = ready_o;
      hs = valid_i && ready_o;
      @(posedge clk);
      if (hs) accepted++;
    end
    #1;
    checkEq("bp_accepted_two", accepted, 32'd2);
    checkEq("bp_ready_before_2nd", {31'd0, rdyAt[1]}, 32'd1);
    checkEq("bp_ready_after_2nd", {31'd0, rdyAt[2]}, 32'd0);
    checkEq("bp_ready_held", {31'd0, ready_o}, 32'd0);
    checkEq("bp_valid_held", {31'd0, valid_o}, 32'd1);
    checkEq("bp_res_stable", {16'd0, res_o}, {16'd0, bpExp[0]});

    // Drain: results must come out in order, exactly once each.
    @(negedge clk) ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 12 && n < 3; c++) begin
      #1;
      if (valid_o) begin
        got[n] = res_o;
        n++;
      end
      hs = valid_i && ready_o;
      @(posedge clk);
      #1;
      if (hs) begin
        accepted++;
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    checkEq("bp_accepted_three", accepted, 32'd3);
    checkEq("bp_result_count", n, 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("bp_order_%0d", i), {16'd0, got[i]}, {16'd0, bpExp[i]});
    end
    checkEq("bp_no_duplicate", {31'd0, valid_o}, 32'd0);
    checkEq("bp_sticky", {29'd0, flags_o}, 32'h1);

    // Reset while both stages are full and the consumer is stalled.
    ready_i = 1'b0;
    s_i = 1'b0; e_i = 8'h7F; f_i = 12'h404; rndMode_i = RNE; valid_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkEq("stall_full_ready", {31'd0, ready_o}, 32'd0);
    checkEq("stall_full_valid", {31'd0, valid_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkEq("rst_mid_valid", {31'd0, valid_o}, 32'd0);
    checkEq("rst_mid_flags", {29'd0, flags_o}, 32'h0);
    checkEq("rst_mid_res", {16'd0, res_o}, 32'd0);
    checkEq("rst_mid_ready", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checkEq("post_rst_valid", {31'd0, valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
